// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction fetch sequencer with one outstanding bus request and a
// single-entry output buffer toward the IF/ID stage.
// Optional feature macro: FETCH_CTRL_ERR_TRAP_EN. When it is defined, a bus error
// response parks the fetcher in FAULT until a redirect arrives. When it is
// undefined, the error flag only travels with the instruction and fault_o stays 0.
// The next PC always comes from outside (pc_next_i / redirect_pc_i). The fetcher
// never adds to the PC itself.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        req_valid_o,
    input  logic        req_ready_i,
    output logic [31:0] req_pc_o,
    input  logic        resp_valid_i,
    output logic        resp_ready_o,
    input  logic        resp_err_i,
    input  logic [31:0] resp_instr_i,
    input  logic [31:0] pc_next_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        halt_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] out_instr_o,
    output logic [31:0] out_pc_o,
    output logic        out_err_o,
    output logic        fault_o
);

`ifdef FETCH_CTRL_ERR_TRAP_EN
    localparam bit ERR_TRAP_EN = 1'b1;
`else
    localparam bit ERR_TRAP_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_FAULT = 3'd4
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        buf_valid_q, buf_valid_d;
    logic [31:0] buf_instr_q, buf_instr_d;
    logic [31:0] buf_pc_q, buf_pc_d;
    logic        buf_err_q, buf_err_d;
    logic        fault_q, fault_d;

    logic req_hs;
    logic resp_hs;
    logic out_hs;

    assign req_hs  = req_valid_o & req_ready_i;
    assign resp_hs = resp_valid_i & resp_ready_o;
    assign out_hs  = buf_valid_q & out_ready_i;

    // State and datapath registers. Reset aborts any transaction at once.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            pc_q        <= RESET_PC;
            buf_valid_q <= 1'b0;
            buf_instr_q <= '0;
            buf_pc_q    <= '0;
            buf_err_q   <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            buf_valid_q <= buf_valid_d;
            buf_instr_q <= buf_instr_d;
            buf_pc_q    <= buf_pc_d;
            buf_err_q   <= buf_err_d;
            fault_q     <= fault_d;
        end
    end

    // Next state, PC and buffer. A redirect overrides everything else.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        buf_valid_d = buf_valid_q & ~out_hs;
        buf_instr_d = buf_instr_q;
        buf_pc_d    = buf_pc_q;
        buf_err_d   = buf_err_q;
        fault_d     = fault_q;

        case (state_q)
            ST_IDLE: begin
                if (redirect_i) begin
                    pc_d    = redirect_pc_i;
                    state_d = ST_REQ;
                end else if (!halt_i) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (redirect_i) begin
                    pc_d = redirect_pc_i;
                    // An accepted stale request still owes a response, so it must be drained.
                    state_d = req_hs ? ST_DRAIN : ST_REQ;
                end else if (req_hs) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (redirect_i) begin
                    pc_d    = redirect_pc_i;
                    state_d = resp_hs ? ST_REQ : ST_DRAIN;
                end else if (resp_hs) begin
                    buf_valid_d = 1'b1;
                    buf_instr_d = resp_instr_i;
                    buf_pc_d    = pc_q;
                    buf_err_d   = resp_err_i;
                    if (ERR_TRAP_EN && resp_err_i) begin
                        state_d = ST_FAULT;
                        fault_d = 1'b1;
                    end else begin
                        pc_d    = pc_next_i;
                        state_d = halt_i ? ST_IDLE : ST_REQ;
                    end
                end
            end
            ST_DRAIN: begin
                // The stale response is swallowed. A redirect only retargets the PC.
                if (redirect_i) begin
                    pc_d = redirect_pc_i;
                end
                if (resp_hs) begin
                    state_d = ST_REQ;
                end
            end
            ST_FAULT: begin
                if (redirect_i) begin
                    pc_d    = redirect_pc_i;
                    state_d = ST_REQ;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (redirect_i) begin
            buf_valid_d = 1'b0;
            fault_d     = 1'b0;
        end
    end

    // Bus-side handshake outputs decoded from the current state.
    always_comb begin
        req_valid_o  = (state_q == ST_REQ);
        resp_ready_o = 1'b0;
        case (state_q)
            ST_WAIT:  resp_ready_o = ~buf_valid_q | out_ready_i;
            ST_DRAIN: resp_ready_o = 1'b1;
            default:  resp_ready_o = 1'b0;
        endcase
    end

    assign req_pc_o    = pc_q;
    assign out_valid_o = buf_valid_q;
    assign out_instr_o = buf_instr_q;
    assign out_pc_o    = buf_pc_q;
    assign out_err_o   = buf_err_q;
    assign fault_o     = fault_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Testbench for fetch_ctrl. It applies directed scenarios and then randomized
// traffic. A bus responder model answers every accepted request. A transaction-level
// reference model predicts all outputs, and they are compared on every falling edge.
module tb_fetch_ctrl;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;
`ifdef FETCH_CTRL_ERR_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_i;
    logic        req_valid_o, req_ready_i;
    logic [31:0] req_pc_o;
    logic        resp_valid_i, resp_ready_o, resp_err_i;
    logic [31:0] resp_instr_i, pc_next_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        halt_i;
    logic        out_valid_o, out_ready_i;
    logic [31:0] out_instr_o, out_pc_o;
    logic        out_err_o, fault_o;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    fetch_ctrl #(.RESET_PC(RESET_PC)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .req_valid_o(req_valid_o), .req_ready_i(req_ready_i), .req_pc_o(req_pc_o),
        .resp_valid_i(resp_valid_i), .resp_ready_o(resp_ready_o),
        .resp_err_i(resp_err_i), .resp_instr_i(resp_instr_i), .pc_next_i(pc_next_i),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i), .halt_i(halt_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_instr_o(out_instr_o), .out_pc_o(out_pc_o), .out_err_o(out_err_o),
        .fault_o(fault_o)
    );

    // Reference model: what the fetcher is doing, expressed as transaction flags.
    logic [31:0] m_pc, m_buf_instr, m_buf_pc;
    logic        m_buf_v, m_buf_err, m_fault;
    logic        m_want;        // a request is being presented
    logic        m_outstanding; // a request was accepted and its response is due
    logic        m_discard;     // that due response is stale
    logic        m_parked;      // waiting for halt to drop (after reset or halt)
    logic        exp_resp_ready;
    logic        m_req_hs, m_resp_hs, m_out_hs;

    // Bus responder state and knobs.
    logic        rand_mode = 1'b0;
    logic        rsp_pend;
    int          rsp_delay;
    logic [31:0] rsp_instr, rsp_next;
    logic        rsp_err;
    int          knob_delay = 0;
    logic [31:0] knob_instr = 32'h0;
    logic [31:0] knob_next = 32'h0;
    logic        knob_err = 1'b0;
    logic        s_req_hs, s_resp_hs;
    logic [31:0] s_req_pc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = RESET_PC; m_buf_v = 1'b0; m_buf_instr = '0; m_buf_pc = '0;
        m_buf_err = 1'b0; m_fault = 1'b0; m_want = 1'b0; m_outstanding = 1'b0;
        m_discard = 1'b0; m_parked = 1'b1;
        rsp_pend = 1'b0; rsp_delay = 0; rsp_instr = '0; rsp_next = '0; rsp_err = 1'b0;
    endtask

    task automatic compare_model();
        exp_resp_ready = m_outstanding && (m_discard || !m_buf_v || out_ready_i);
        chk("req_valid", {31'b0, req_valid_o}, {31'b0, m_want});
        if (m_want) chk("req_pc", req_pc_o, m_pc);
        chk("resp_ready", {31'b0, resp_ready_o}, {31'b0, exp_resp_ready});
        chk("out_valid", {31'b0, out_valid_o}, {31'b0, m_buf_v});
        chk("fault", {31'b0, fault_o}, {31'b0, m_fault});
        if (m_buf_v) begin
            chk("out_instr", out_instr_o, m_buf_instr);
            chk("out_pc", out_pc_o, m_buf_pc);
            chk("out_err", {31'b0, out_err_o}, {31'b0, m_buf_err});
        end
    endtask

    task automatic model_update();
        if (m_out_hs) m_buf_v = 1'b0;
        if (redirect_i) begin
            m_pc = redirect_pc_i; m_fault = 1'b0; m_buf_v = 1'b0; m_parked = 1'b0;
            if (m_req_hs || (m_outstanding && !m_resp_hs)) begin
                m_outstanding = 1'b1; m_discard = 1'b1; m_want = 1'b0;
            end else begin
                m_outstanding = 1'b0; m_discard = 1'b0; m_want = 1'b1;
            end
        end else if (m_want) begin
            if (m_req_hs) begin
                m_want = 1'b0; m_outstanding = 1'b1; m_discard = 1'b0;
            end
        end else if (m_outstanding && m_resp_hs) begin
            m_outstanding = 1'b0;
            if (m_discard) begin
                m_discard = 1'b0; m_want = 1'b1;
            end else begin
                m_buf_v = 1'b1; m_buf_instr = resp_instr_i; m_buf_pc = m_pc;
                m_buf_err = resp_err_i;
                if (TRAP && resp_err_i) begin
                    m_fault = 1'b1;
                end else begin
                    m_pc = pc_next_i; m_want = !halt_i; m_parked = halt_i;
                end
            end
        end else if (m_parked && !halt_i) begin
            m_parked = 1'b0; m_want = 1'b1;
        end
    endtask

    task automatic responder_update();
        if (rsp_pend && s_resp_hs) rsp_pend = 1'b0;
        else if (rsp_pend && rsp_delay > 0) rsp_delay--;
        if (s_req_hs) begin
            if (rand_mode) begin
                knob_delay = $urandom_range(0, 2);
                knob_instr = $urandom;
                knob_err   = ($urandom_range(0, 7) == 0);
                knob_next  = ($urandom_range(0, 3) == 0) ? ($urandom & 32'hFFFF_FFFC) : s_req_pc + 32'd4;
            end
            rsp_pend = 1'b1; rsp_delay = knob_delay; rsp_instr = knob_instr;
            rsp_next = knob_next; rsp_err = knob_err;
        end
    endtask

    task automatic responder_drive();
        resp_valid_i = rsp_pend && (rsp_delay == 0);
        resp_instr_i = rsp_pend ? rsp_instr : 32'h0;
        pc_next_i    = rsp_pend ? rsp_next : 32'h0;
        resp_err_i   = rsp_pend ? rsp_err : 1'b0;
    endtask

    // One clock cycle: compare on the falling edge, then advance the models on the rising edge.
    task automatic step();
        @(negedge clk);
        compare_model();
        s_req_hs  = req_valid_o && req_ready_i;
        s_resp_hs = resp_valid_i && resp_ready_o;
        s_req_pc  = req_pc_o;
        m_req_hs  = m_want && req_ready_i;
        m_resp_hs = resp_valid_i && exp_resp_ready;
        m_out_hs  = m_buf_v && out_ready_i;
        @(posedge clk);
        model_update();
        responder_update();
        #1;
        responder_drive();
    endtask

    task automatic set_rsp(input int d, input logic [31:0] ins, input logic [31:0] nxt, input logic e);
        knob_delay = d; knob_instr = ins; knob_next = nxt; knob_err = e;
    endtask

    initial begin
        rst_i = 1'b1; req_ready_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
        halt_i = 1'b0; out_ready_i = 1'b0;
        model_reset();
        responder_drive();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_valid", {31'b0, req_valid_o}, 32'd0);
        chk("rst_resp_ready", {31'b0, resp_ready_o}, 32'd0);
        chk("rst_out_valid", {31'b0, out_valid_o}, 32'd0);
        chk("rst_out_instr", out_instr_o, 32'h0);
        chk("rst_out_pc", out_pc_o, 32'h0);
        chk("rst_out_err", {31'b0, out_err_o}, 32'd0);
        chk("rst_fault", {31'b0, fault_o}, 32'd0);
        rst_i = 1'b0;

        // The first request appears in the second cycle after reset release.
        step();
        chk("first_req_valid", {31'b0, req_valid_o}, 32'd1);
        chk("first_req_pc", req_pc_o, 32'h8000_0000);

        // Basic fetch with a one-cycle response.
        req_ready_i = 1'b1; out_ready_i = 1'b1;
        set_rsp(0, 32'h0000_0013, 32'h8000_0004, 1'b0);
        step();
        step();
        chk("basic_out_valid", {31'b0, out_valid_o}, 32'd1);
        chk("basic_out_instr", out_instr_o, 32'h0000_0013);
        chk("basic_out_pc", out_pc_o, 32'h8000_0000);
        chk("basic_next_req_valid", {31'b0, req_valid_o}, 32'd1);
        chk("basic_next_req_pc", req_pc_o, 32'h8000_0004);

        // Back-pressure: the buffer is full and the consumer stalls for 5 cycles.
        out_ready_i = 1'b0;
        set_rsp(0, 32'h0010_0093, 32'h8000_0008, 1'b0);
        step();
        for (int i = 0; i < 5; i++) begin
            chk("stall_resp_ready", {31'b0, resp_ready_o}, 32'd0);
            chk("stall_out_instr", out_instr_o, 32'h0000_0013);
            step();
        end
        out_ready_i = 1'b1;
        #1;
        chk("release_resp_ready", {31'b0, resp_ready_o}, 32'd1);
        step();
        chk("b2b_out_valid", {31'b0, out_valid_o}, 32'd1);
        chk("b2b_out_instr", out_instr_o, 32'h0010_0093);
        chk("b2b_out_pc", out_pc_o, 32'h8000_0004);
        chk("b2b_req_pc", req_pc_o, 32'h8000_0008);

        // Redirect while waiting; the late response is drained.
        set_rsp(1, 32'h1111_1111, 32'h8000_000C, 1'b0);
        step();
        redirect_i = 1'b1; redirect_pc_i = 32'h8000_0100;
        step();
        redirect_i = 1'b0;
        chk("drain_resp_ready", {31'b0, resp_ready_o}, 32'd1);
        chk("drain_out_valid", {31'b0, out_valid_o}, 32'd0);
        step();
        chk("after_drain_out_valid", {31'b0, out_valid_o}, 32'd0);
        chk("after_drain_req_pc", req_pc_o, 32'h8000_0100);

        // Redirect coincident with the response handshake.
        set_rsp(0, 32'h2222_2222, 32'h8000_0104, 1'b0);
        step();
        redirect_i = 1'b1; redirect_pc_i = 32'h8000_0200;
        step();
        redirect_i = 1'b0;
        chk("coinc_out_valid", {31'b0, out_valid_o}, 32'd0);
        chk("coinc_req_valid", {31'b0, req_valid_o}, 32'd1);
        chk("coinc_req_pc", req_pc_o, 32'h8000_0200);

        // Halt asserted during WAIT.
        set_rsp(1, 32'h0020_0113, 32'h8000_0204, 1'b0);
        step();
        halt_i = 1'b1;
        step();
        step();
        chk("halt_out_valid", {31'b0, out_valid_o}, 32'd1);
        chk("halt_out_pc", out_pc_o, 32'h8000_0200);
        for (int i = 0; i < 3; i++) begin
            chk("halt_req_valid", {31'b0, req_valid_o}, 32'd0);
            step();
        end
        halt_i = 1'b0;
        step();
        chk("unhalt_req_pc", req_pc_o, 32'h8000_0204);

        // Error response fetched at 0x8000_0008.
        req_ready_i = 1'b0; redirect_i = 1'b1; redirect_pc_i = 32'h8000_0008;
        step();
        redirect_i = 1'b0; req_ready_i = 1'b1;
        chk("err_setup_req_pc", req_pc_o, 32'h8000_0008);
        set_rsp(0, 32'hDEAD_BEEF, 32'h8000_000C, 1'b1);
        step();
        step();
        set_rsp(0, 32'h0000_0013, 32'h0, 1'b0);
        chk("err_out_err", {31'b0, out_err_o}, 32'd1);
        chk("err_out_pc", out_pc_o, 32'h8000_0008);
        if (TRAP) begin
            for (int i = 0; i < 3; i++) begin
                chk("trap_fault", {31'b0, fault_o}, 32'd1);
                chk("trap_req_valid", {31'b0, req_valid_o}, 32'd0);
                step();
            end
            redirect_i = 1'b1; redirect_pc_i = 32'h8000_0040;
            step();
            redirect_i = 1'b0;
            chk("trap_exit_fault", {31'b0, fault_o}, 32'd0);
            chk("trap_exit_req_pc", req_pc_o, 32'h8000_0040);
        end else begin
            chk("noerr_trap_fault", {31'b0, fault_o}, 32'd0);
            chk("noerr_trap_req_valid", {31'b0, req_valid_o}, 32'd1);
            chk("noerr_trap_req_pc", req_pc_o, 32'h8000_000C);
        end

        // Reset in the middle of a transaction aborts it immediately.
        step();
        rst_i = 1'b1;
        #1;
        chk("midrst_req_valid", {31'b0, req_valid_o}, 32'd0);
        chk("midrst_resp_ready", {31'b0, resp_ready_o}, 32'd0);
        chk("midrst_out_valid", {31'b0, out_valid_o}, 32'd0);
        @(posedge clk);
        #1;
        model_reset();
        responder_drive();
        rst_i = 1'b0;
        step();
        chk("midrst_first_req_pc", req_pc_o, 32'h8000_0000);

        // Randomized traffic.
        rand_mode = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            req_ready_i   = ($urandom_range(0, 3) != 0);
            out_ready_i   = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 15) == 0) halt_i = ~halt_i;
            redirect_i    = ($urandom_range(0, 19) == 0);
            redirect_pc_i = $urandom & 32'hFFFF_FFFC;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
